// File: rtl/sccomp_run_ctrl.sv
// sccomp_run_ctrl: run controller and state-dump engine for the sccomp CPU.
// Gates the CPU with a clock enable and counts retired instructions.
// Halts on an instruction limit, a PC breakpoint or an external request.
// After a halt it streams the register file out over a valid/ready channel.
module sccomp_run_ctrl #(
    parameter int STOP_INSTR = 200,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int NBRK       = 2,
    localparam int BRK_W     = (NBRK > 1) ? $clog2(NBRK) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [31:0]          max_instr,
    input  logic                 retire,
    input  logic [PC_W-1:0]      pc,
    input  logic [NBRK-1:0]      brk_en,
    input  logic [NBRK*PC_W-1:0] brk_pc,
    output logic                 cpu_en,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [BRK_W-1:0]     brk_hit,
    output logic [31:0]          instr_count,
    output logic [4:0]           reg_sel,
    input  logic [DATA_W-1:0]    reg_data,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [4:0]           dump_idx,
    output logic [DATA_W-1:0]    dump_data,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_LIMIT = 2'b01;
    localparam logic [1:0] CAUSE_BRK   = 2'b10;
    localparam logic [1:0] CAUSE_EXT   = 2'b11;

    state_t             state;
    state_t             next_state;
    logic [31:0]        limit;
    logic               first_retire;
    logic [31:0]        count_next;
    logic               brk_any;
    logic [BRK_W-1:0]   brk_idx;
    logic               brk_fire;
    logic               limit_fire;
    logic               halt_fire;
    logic               last_beat;

    assign count_next = instr_count + 32'd1;
    assign last_beat  = (reg_sel == 5'(NREG - 1));

    // Find the lowest enabled breakpoint channel whose address matches the retiring PC
    always_comb begin
        brk_any = 1'b0;
        brk_idx = '0;
        for (int k = NBRK - 1; k >= 0; k--) begin
            if (brk_en[k] && (pc == brk_pc[k*PC_W +: PC_W])) begin
                brk_any = 1'b1;
                brk_idx = BRK_W'(k);
            end
        end
    end

    // The first retire after (re)starting is masked so resuming from a breakpoint PC does not re-trigger
    assign brk_fire   = retire && brk_any && !first_retire;
    assign limit_fire = retire && (count_next == limit);
    assign halt_fire  = brk_fire || limit_fire || halt_req;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        next_state = state;
        cpu_en     = 1'b0;
        halted     = 1'b0;
        dump_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                cpu_en = 1'b1;
                if (halt_fire) next_state = DUMP;
            end
            DUMP: begin
                halted     = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready && last_beat) next_state = DONE;
            end
            DONE: begin
                halted = 1'b1;
                done   = 1'b1;
                if (start) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter, limit, halt cause and dump index bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            instr_count  <= '0;
            limit        <= 32'(STOP_INSTR);
            first_retire <= 1'b1;
            halt_cause   <= '0;
            brk_hit      <= '0;
            reg_sel      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        instr_count  <= '0;
                        limit        <= (max_instr == 32'd0) ? 32'(STOP_INSTR) : max_instr;
                        first_retire <= 1'b1;
                        halt_cause   <= '0;
                        brk_hit      <= '0;
                        reg_sel      <= '0;
                    end
                end
                RUN: begin
                    if (retire) begin
                        instr_count  <= count_next;
                        first_retire <= 1'b0;
                    end
                    if (brk_fire) begin
                        halt_cause <= CAUSE_BRK;
                        brk_hit    <= brk_idx;
                    end else if (limit_fire) begin
                        halt_cause <= CAUSE_LIMIT;
                    end else if (halt_req) begin
                        halt_cause <= CAUSE_EXT;
                    end
                    if (halt_fire) reg_sel <= '0;
                end
                DUMP: begin
                    if (dump_ready && !last_beat) reg_sel <= reg_sel + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Register 0 is hardwired to zero in the CPU, so its beat always carries 0
    assign dump_idx  = reg_sel;
    assign dump_data = (state == DUMP && reg_sel != 5'd0) ? reg_data : '0;

endmodule
